// File: rtl/mcp_instr_encoder.sv
// Packs MIPS R/I/J instruction fields into 32-bit words, buffers them in a small FIFO
// and emits them with a running byte address. Optional macro: MCP_ENC_CHECK_EN.
module mcp_instr_encoder #(
  parameter int              WL        = 32,
  parameter int              DEPTH     = 4,
  parameter logic [WL-1:0]   BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    fmt,
  input  logic [5:0]    opcode,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   Imm,
  input  logic [25:0]   jumpt,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [WL-1:0] out_data,
  output logic [WL-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    err_cnt
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   LP_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  logic [WL-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [WL-1:0] r_addr;
  logic [7:0]    r_err_cnt;

  logic [WL-1:0] w_word;
  logic          w_reject;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  // Field packing; fields not used by the selected format are ignored.
  always_comb begin
    w_word = '0;
    case (fmt)
      FMT_R:   w_word = WL'({opcode, rs, rt, rd, shamt, funct});
      FMT_I:   w_word = WL'({opcode, rs, rt, Imm});
      FMT_J:   w_word = WL'({opcode, jumpt});
      default: w_word = '0;
    endcase
  end

  always_comb begin
    w_reject = (fmt == 2'b11);
`ifdef MCP_ENC_CHECK_EN
    if (fmt == FMT_R && opcode != 6'h00) w_reject = 1'b1;
    if ((fmt == FMT_I || fmt == FMT_J) && opcode == 6'h00) w_reject = 1'b1;
    if (fmt == FMT_J && opcode != 6'h02 && opcode != 6'h03) w_reject = 1'b1;
`endif
  end

  // Handshake: a bundle transfers on in_valid && in_ready, a word on out_valid && out_ready,
  // both at the rising edge. in_ready depends only on occupancy, so a full FIFO refuses
  // input even while the head is being popped, and a pushed word is poppable one edge later.
  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  assign w_accept = in_valid && !w_full;
  assign w_push   = w_accept && !w_reject;
  assign w_pop    = !w_empty && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_addr    <= BASE_ADDR;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_addr + WL'(4);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept && w_reject && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // Head is masked while empty so stale or uninitialised entries never show.
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_addr  = r_addr;
  assign out_valid = !w_empty;
  assign in_ready  = !w_full;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/mcp_instr_encoder.md
Name: mcp_instr_encoder

Overview:
- Packs MIPS instruction fields (opcode, rs, rt, rd, shamt, funct, Imm, jump target) into 32-bit R-, I- or J-format words.
- Buffers the packed words in a small FIFO and presents them with a running byte address.
- Its purpose is loading instruction memory for the multicycle processor from a test sequencer or loader.
- It performs the inverse of the field-extraction step in the datapath.

Parameters:
- WL, 32, instruction word width; the field layout is fixed for WL=32.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fmt  input  2  instruction format: 00=R, 01=I, 10=J, 11=reserved.
- opcode  input  6  opcode field.
- rs  input  5  source register.
- rt  input  5  target register.
- rd  input  5  destination register (R only).
- shamt  input  5  shift amount (R only).
- funct  input  6  function code (R only).
- Imm  input  16  immediate (I only).
- jumpt  input  26  jump target (J only).
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- out_data  output  WL  encoded instruction at the FIFO head.
- out_addr  output  WL  byte address of out_data.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- err_cnt  output  8  count of rejected bundles, saturating at 8'hFF.

Behaviour:
Reset (rst=1 at a clock edge; also applies mid-operation):
- FIFO emptied; pending words are discarded and not emitted.
- out_valid=0, out_data=0, out_addr=BASE_ADDR, err_cnt=0, in_ready=1 on the following cycle.

Encoding (combinational from inputs):
- R: {opcode, rs, rt, rd, shamt, funct}.
- I: {opcode, rs, rt, Imm}.
- J: {opcode, jumpt}.
- Unused fields are ignored. No sign extension.

Input handshake:
- A bundle is accepted when in_valid && in_ready at a clock edge.
- in_ready = !full, registered-free from the count.
- When full, in_ready=0 even if out_ready=1 in the same cycle; there is no full-pass-through.
- Rejected bundle (fmt=11): consumed (in_ready still gates acceptance), not written to the FIFO; err_cnt increments unless already 8'hFF.

Output handshake:
- out_valid = !empty.
- out_data is the FIFO head.
- A word is consumed on out_valid && out_ready. out_addr then advances by 4, wrapping modulo 2^WL.
- out_data and out_addr hold stable while out_valid && !out_ready.

Latency and throughput:
- A bundle accepted at edge N is visible at out_valid/out_data after edge N (one-cycle latency), including when the FIFO is empty. There is no combinational in-to-out path.
- Simultaneous push and pop when not full: count unchanged, order preserved, one word per cycle sustained.
- Push when empty with out_ready=1: the word appears the next cycle; it is never consumed in the cycle it arrives.

Pointers:
- Read and write pointers use log2(DEPTH) bits and wrap naturally.
- Occupancy counter is log2(DEPTH)+1 bits, from 0 to DEPTH.
- full = (count==DEPTH); empty = (count==0).

Optional Feature:
MCP_ENC_CHECK_EN
- When defined, additional format consistency checks apply:
  - R format with opcode != 6'h00 is rejected.
  - I or J format with opcode == 6'h00 is rejected.
  - J format with opcode not in {6'h02, 6'h03} is rejected.
- Rejected bundles are consumed, not pushed, and increment err_cnt.
- When not defined, only fmt=11 is rejected; any opcode is encoded as given.

Test Plan:
1. After reset, R bundle opcode=0 rs=10 rt=11 rd=9 shamt=0 funct=6'h20 -> next cycle out_valid=1, out_data=32'h014B4820, out_addr=BASE_ADDR.
2. I bundle opcode=8 rs=0 rt=8 Imm=5, then J bundle opcode=2 jumpt=26'h0100000, out_ready=1 -> 32'h20080005 at addr 0, then 32'h08100000 at addr 4, in order.
3. out_ready=0, push 4 bundles (DEPTH=4) -> in_ready=0 after the 4th; a 5th in_valid is held. Raise out_ready -> 4 words drain in order with addresses 0, 4, 8, 12. The 5th is accepted only after a slot frees.
4. fmt=11 bundle -> no out_valid, err_cnt=1. Then 300 reserved bundles -> err_cnt=8'hFF, saturated.
5. With MCP_ENC_CHECK_EN: R bundle with opcode=8 -> rejected, err_cnt increments. Without the macro -> encoded as 32'h2...; verify the bit pattern.
6. Three words buffered, assert rst for one cycle mid-stream -> out_valid=0, out_addr=BASE_ADDR, err_cnt=0. The next bundle is emitted at BASE_ADDR; stale words never appear.
